// File: rtl/hni_qos_rr_sel.sv
// Two-class (QoS high/low) round-robin entry selector for hni_qos.
// Define HNI_QOS_STARVE_EN to promote the low class after STARVE_TH high grants.
module hni_qos_rr_sel #(
  parameter int ENTRIES_NUM = 16,
  parameter int IDX_W       = 4,
  parameter int QOS_W       = 4,
  parameter int QOS_HI_TH   = 8,
  parameter int STARVE_TH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ENTRIES_NUM-1:0]       req_entry_vec,
  input  logic [ENTRIES_NUM*QOS_W-1:0] req_entry_qos,
  input  logic                         upd_start_entry,
  input  logic                         sel_ack,
  output logic [ENTRIES_NUM-1:0]       req_entry_ptr_sel,
  output logic                         sel_vld,
  output logic [IDX_W-1:0]             sel_idx,
  output logic                         sel_hi
);

  if (ENTRIES_NUM < 2 || (2**IDX_W) < ENTRIES_NUM ||
      STARVE_TH < 1 || STARVE_TH > 255) begin : g_bad_cfg
    $error("hni_qos_rr_sel: illegal parameter set");
  end

  logic [ENTRIES_NUM-1:0] r_vec;
  logic [ENTRIES_NUM-1:0] r_hi;
  logic [IDX_W-1:0]       r_ptr_hi;
  logic [IDX_W-1:0]       r_ptr_lo;

  logic [ENTRIES_NUM-1:0] w_hi_new;
  logic [ENTRIES_NUM-1:0] w_hv;
  logic [ENTRIES_NUM-1:0] w_lv;
  logic [IDX_W:0]         w_rr_hi;
  logic [IDX_W:0]         w_rr_lo;
  logic                   w_force_lo;
  logic                   w_pick_hi;
  logic                   w_vld;
  logic [IDX_W-1:0]       w_idx;
  logic [IDX_W-1:0]       w_ptr_nxt;
  logic                   w_fire;

  // First set bit at or above p, else the lowest set bit overall.
  function automatic logic [IDX_W:0] f_rr(
    input logic [ENTRIES_NUM-1:0] v,
    input logic [IDX_W-1:0]       p
  );
    logic             hit_up;
    logic             hit_any;
    logic [IDX_W-1:0] i_up;
    logic [IDX_W-1:0] i_any;
    hit_up  = 1'b0;
    hit_any = 1'b0;
    i_up    = '0;
    i_any   = '0;
    for (int i = ENTRIES_NUM - 1; i >= 0; i--) begin
      if (v[i]) begin
        hit_any = 1'b1;
        i_any   = IDX_W'(i);
        if (IDX_W'(i) >= p) begin
          hit_up = 1'b1;
          i_up   = IDX_W'(i);
        end
      end
    end
    return hit_up ? {1'b1, i_up} : {hit_any, i_any};
  endfunction

  always_comb begin
    w_hi_new = '0;
    for (int i = 0; i < ENTRIES_NUM; i++) begin
      w_hi_new[i] = 32'(req_entry_qos[i*QOS_W +: QOS_W]) >= QOS_HI_TH;
    end
  end

  assign w_hv    = r_vec & r_hi;
  assign w_lv    = r_vec & ~r_hi;
  assign w_rr_hi = f_rr(w_hv, r_ptr_hi);
  assign w_rr_lo = f_rr(w_lv, r_ptr_lo);

  assign w_pick_hi = w_rr_hi[IDX_W] && !(w_force_lo && w_rr_lo[IDX_W]);
  assign w_vld     = w_rr_hi[IDX_W] || w_rr_lo[IDX_W];
  assign w_idx     = !w_vld     ? '0 :
                     w_pick_hi ? w_rr_hi[IDX_W-1:0] : w_rr_lo[IDX_W-1:0];
  assign w_fire    = sel_ack && w_vld;
  assign w_ptr_nxt = (w_idx == IDX_W'(ENTRIES_NUM - 1)) ? '0 : w_idx + 1'b1;

  always_comb begin
    req_entry_ptr_sel = '0;
    for (int i = 0; i < ENTRIES_NUM; i++) begin
      req_entry_ptr_sel[i] = w_vld && (w_idx == IDX_W'(i));
    end
  end

  assign sel_vld = w_vld;
  assign sel_idx = w_idx;
  assign sel_hi  = w_vld && w_pick_hi;

  // A fresh snapshot wins over the ack's bit-clear; pointers still advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec    <= '0;
      r_hi     <= '0;
      r_ptr_hi <= '0;
      r_ptr_lo <= '0;
    end else begin
      if (upd_start_entry) begin
        r_vec <= req_entry_vec;
        r_hi  <= w_hi_new;
      end else if (w_fire) begin
        r_vec[w_idx] <= 1'b0;
      end
      if (w_fire) begin
        if (w_pick_hi) r_ptr_hi <= w_ptr_nxt;
        else           r_ptr_lo <= w_ptr_nxt;
      end
    end
  end

`ifdef HNI_QOS_STARVE_EN
  logic [7:0] r_starve;

  assign w_force_lo = r_starve >= 8'(STARVE_TH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_fire) begin
      if (w_pick_hi && w_lv != '0) begin
        if (r_starve < 8'(STARVE_TH)) r_starve <= r_starve + 8'd1;
      end else begin
        r_starve <= '0;
      end
    end
  end
`else
  assign w_force_lo = 1'b0;
`endif

endmodule

// File: tb/tb_hni_qos_rr_sel.sv
// Directed-vector bench for hni_qos_rr_sel (8 entries, STARVE_TH=2).
// Expected pick orders are hand-derived; HNI_QOS_STARVE_EN selects the order.
module tb_hni_qos_rr_sel;

  logic        clk;
  logic        rst;
  logic [7:0]  req_entry_vec;
  logic [31:0] req_entry_qos;
  logic        upd_start_entry;
  logic        sel_ack;
  logic [7:0]  req_entry_ptr_sel;
  logic        sel_vld;
  logic [2:0]  sel_idx;
  logic        sel_hi;

  int n_vec;
  int n_err;

  hni_qos_rr_sel #(
    .ENTRIES_NUM(8),
    .IDX_W      (3),
    .QOS_W      (4),
    .QOS_HI_TH  (8),
    .STARVE_TH  (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_entry_vec    (req_entry_vec),
    .req_entry_qos    (req_entry_qos),
    .upd_start_entry  (upd_start_entry),
    .sel_ack          (sel_ack),
    .req_entry_ptr_sel(req_entry_ptr_sel),
    .sel_vld          (sel_vld),
    .sel_idx          (sel_idx),
    .sel_hi           (sel_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic upd, input logic ack,
                       input logic [7:0] vec, input logic [31:0] qos);
    upd_start_entry = upd;
    sel_ack         = ack;
    req_entry_vec   = vec;
    req_entry_qos   = qos;
    tick();
    upd_start_entry = 1'b0;
    sel_ack         = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 32'h0);
    n_vec++;
    if ({req_entry_ptr_sel, sel_vld, sel_idx, sel_hi} !== 13'h0) begin
      n_err++;
      $display("FAIL reset_outs: got sel=%h vld=%b idx=%0d hi=%b want all 0",
               req_entry_ptr_sel, sel_vld, sel_idx, sel_hi);
    end
    rst = 1'b0;
    drive(1'b1, 1'b0, 8'h00, 32'h2222_2222);
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if (sel_vld !== 1'b0 || req_entry_ptr_sel !== 8'h00 || sel_idx !== 3'd0) begin
        n_err++;
        $display("FAIL empty_c%0d: got vld=%b sel=%h idx=%0d want 0/00/0",
                 c, sel_vld, req_entry_ptr_sel, sel_idx);
      end
      drive(1'b0, 1'b1, 8'hFF, 32'hFFFF_FFFF);
    end
  endtask

  task automatic test_rr_lo();
    logic [2:0] exp_idx [3];
    exp_idx = '{3'd0, 3'd2, 3'd5};
    drive(1'b1, 1'b0, 8'h25, 32'h2222_2222);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (sel_vld !== 1'b1 || sel_idx !== exp_idx[k] || sel_hi !== 1'b0 ||
          req_entry_ptr_sel !== (8'h01 << exp_idx[k])) begin
        n_err++;
        $display("FAIL rr_lo_%0d: got vld=%b idx=%0d hi=%b sel=%h want idx=%0d lo",
                 k, sel_vld, sel_idx, sel_hi, req_entry_ptr_sel, exp_idx[k]);
      end
      // Input changes without upd must not reach the outputs.
      drive(1'b0, 1'b1, 8'hFF, 32'hFFFF_FFFF);
    end
    n_vec++;
    if (sel_vld !== 1'b0 || req_entry_ptr_sel !== 8'h00) begin
      n_err++;
      $display("FAIL rr_lo_drain: got vld=%b sel=%h want 0/00",
               sel_vld, req_entry_ptr_sel);
    end
    drive(1'b1, 1'b0, 8'h25, 32'h2222_2222);
    n_vec++;
    if (sel_vld !== 1'b1 || sel_idx !== 3'd0) begin
      n_err++;
      $display("FAIL rr_lo_wrap: got vld=%b idx=%0d want 1/0", sel_vld, sel_idx);
    end
  endtask

  task automatic test_priority();
    drive(1'b1, 1'b0, 8'h81, 32'hC000_0001);
    n_vec++;
    if (sel_vld !== 1'b1 || sel_idx !== 3'd7 || sel_hi !== 1'b1 ||
        req_entry_ptr_sel !== 8'h80) begin
      n_err++;
      $display("FAIL prio_hi: got vld=%b idx=%0d hi=%b sel=%h want 7 hi 80",
               sel_vld, sel_idx, sel_hi, req_entry_ptr_sel);
    end
    drive(1'b0, 1'b1, 8'h00, 32'h0);
    n_vec++;
    if (sel_vld !== 1'b1 || sel_idx !== 3'd0 || sel_hi !== 1'b0) begin
      n_err++;
      $display("FAIL prio_lo: got vld=%b idx=%0d hi=%b want 0 lo",
               sel_vld, sel_idx, sel_hi);
    end
    drive(1'b0, 1'b1, 8'h00, 32'h0);
    n_vec++;
    if (sel_vld !== 1'b0) begin
      n_err++;
      $display("FAIL prio_drain: got vld=%b want 0", sel_vld);
    end
  endtask

  task automatic test_starve();
    logic [2:0] exp_idx [4];
    logic       exp_hi  [4];
`ifdef HNI_QOS_STARVE_EN
    exp_idx = '{3'd0, 3'd1, 3'd3, 3'd2};
    exp_hi  = '{1'b1, 1'b1, 1'b0, 1'b1};
`else
    exp_idx = '{3'd0, 3'd1, 3'd2, 3'd3};
    exp_hi  = '{1'b1, 1'b1, 1'b1, 1'b0};
`endif
    drive(1'b1, 1'b0, 8'h0F, 32'h0000_0999);
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (sel_vld !== 1'b1 || sel_idx !== exp_idx[k] || sel_hi !== exp_hi[k]) begin
        n_err++;
        $display("FAIL starve_%0d: got vld=%b idx=%0d hi=%b want idx=%0d hi=%b",
                 k, sel_vld, sel_idx, sel_hi, exp_idx[k], exp_hi[k]);
      end
      drive(1'b0, 1'b1, 8'h00, 32'h0);
    end
    n_vec++;
    if (sel_vld !== 1'b0) begin
      n_err++;
      $display("FAIL starve_drain: got vld=%b want 0", sel_vld);
    end
  endtask

  task automatic test_simul();
    drive(1'b1, 1'b0, 8'h04, 32'h2222_2222);
    n_vec++;
    if (sel_vld !== 1'b1 || sel_idx !== 3'd2 || sel_hi !== 1'b0) begin
      n_err++;
      $display("FAIL simul_pre: got vld=%b idx=%0d hi=%b want 2 lo",
               sel_vld, sel_idx, sel_hi);
    end
    drive(1'b1, 1'b1, 8'h04, 32'h2222_2222);
    n_vec++;
    if (sel_vld !== 1'b1 || sel_idx !== 3'd2 || req_entry_ptr_sel !== 8'h04) begin
      n_err++;
      $display("FAIL simul_post: got vld=%b idx=%0d sel=%h want 1/2/04",
               sel_vld, sel_idx, req_entry_ptr_sel);
    end
    // ptr_lo should now be 3, so entry 3 beats entry 2.
    drive(1'b1, 1'b0, 8'h0C, 32'h2222_2222);
    n_vec++;
    if (sel_vld !== 1'b1 || sel_idx !== 3'd3) begin
      n_err++;
      $display("FAIL simul_ptr: got vld=%b idx=%0d want 1/3", sel_vld, sel_idx);
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 1'b0, 8'h01, 32'h0);
    n_vec++;
    if (sel_vld !== 1'b1 || sel_idx !== 3'd0) begin
      n_err++;
      $display("FAIL mrst_pre: got vld=%b idx=%0d want 1/0", sel_vld, sel_idx);
    end
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if ({req_entry_ptr_sel, sel_vld, sel_idx, sel_hi} !== 13'h0) begin
      n_err++;
      $display("FAIL mrst_async: got sel=%h vld=%b idx=%0d hi=%b want all 0",
               req_entry_ptr_sel, sel_vld, sel_idx, sel_hi);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 8'h80, 32'h0);
    n_vec++;
    if (sel_vld !== 1'b1 || sel_idx !== 3'd7 || sel_hi !== 1'b0 ||
        req_entry_ptr_sel !== 8'h80) begin
      n_err++;
      $display("FAIL mrst_after: got vld=%b idx=%0d hi=%b sel=%h want 7 lo 80",
               sel_vld, sel_idx, sel_hi, req_entry_ptr_sel);
    end
  endtask

  initial begin
    n_vec           = 0;
    n_err           = 0;
    rst             = 1'b1;
    req_entry_vec   = '0;
    req_entry_qos   = '0;
    upd_start_entry = 1'b0;
    sel_ack         = 1'b0;
    @(negedge clk);
    test_reset();
    test_rr_lo();
    test_priority();
    test_starve();
    test_simul();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hni_qos_rr_sel.md
Name: hni_qos_rr_sel

Overview:
- Parametrised successor to the HNI single-level entry selector.
- Snapshots the MSHR request vector and a per-entry QoS value, splits entries into high/low priority classes, and round-robins within each class.
- Emits a one-hot pick plus encoded index to hni_qos.
- Tracks per-class rotating pointers, clears granted entries on acknowledge, and optionally promotes the low class after repeated high-class grants.

Parameters:
- ENTRIES_NUM, 16, number of request entries (>=2).
- IDX_W, 4, index width; must satisfy 2**IDX_W >= ENTRIES_NUM.
- QOS_W, 4, per-entry QoS field width.
- QOS_HI_TH, 8, entries with qos >= QOS_HI_TH are high class.
- STARVE_TH, 4, consecutive high-class grants with low pending before promotion (1..255).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_entry_vec  in  ENTRIES_NUM  request-pending bit per entry
- req_entry_qos  in  ENTRIES_NUM*QOS_W  QoS of entry i at bits [i*QOS_W +: QOS_W]
- upd_start_entry  in  1  load new snapshot
- sel_ack  in  1  hni_qos consumed current pick
- req_entry_ptr_sel  out  ENTRIES_NUM  one-hot selected entry, 0 when none
- sel_vld  out  1  a pick is presented
- sel_idx  out  IDX_W  binary index of the pick, 0 when sel_vld=0
- sel_hi  out  1  pick came from the high class

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - snapshot vec_q = 0, hi_q = 0.
  - ptr_hi = ptr_lo = 0.
  - starve_cnt = 0.
  - All outputs 0.
- Snapshot: when upd_start_entry=1 at a clk edge, capture
  - vec_q <= req_entry_vec
  - hi_q[i] <= (qos_i >= QOS_HI_TH), unsigned compare.
- Latency: outputs are combinational from registered state only. A pick is visible the cycle after the upd edge; there is no path from req_* inputs to outputs.
- Class vectors: hv = vec_q & hi_q; lv = vec_q & ~hi_q.
- Round-robin search, per class: the first set bit at index >= ptr, else wrap to the first set bit at index < ptr. ptr = 0 degenerates to lowest-index-first.
- Class choice:
  - force_lo = starve_cnt >= STARVE_TH (feature on).
  - If hv != 0 and not (force_lo and lv != 0), pick from hv (sel_hi=1).
  - Else if lv != 0, pick from lv.
  - Else sel_vld=0.
- On sel_ack & sel_vld:
  - Granted bit of vec_q is cleared.
  - The winning class pointer becomes (idx+1), wrapping to 0 when idx = ENTRIES_NUM-1.
  - The other pointer holds.
- sel_ack while sel_vld=0: ignored, no state change.
- Simultaneous upd_start_entry and valid sel_ack:
  - Pointer and starve_cnt update per the ack.
  - vec_q/hi_q take the new snapshot; the ack's bit-clear is discarded.
- Pointer wrap on a non-power-of-two ENTRIES_NUM: never exceeds ENTRIES_NUM-1.
- Pointers persist across snapshots (fairness across loads); only reset clears them.
- Reset mid-operation: all state cleared asynchronously; outputs drop to 0 immediately.

Optional Feature:
- HNI_QOS_STARVE_EN defined:
  - starve_cnt (8-bit, saturating at STARVE_TH) increments on each acked high-class grant while lv != 0.
  - Clears on any acked low-class grant, or when lv == 0 at an ack.
  - At threshold, the next pick comes from the low class.
- Undefined: starve_cnt is absent (force_lo=0); strict high-over-low priority; STARVE_TH is unused.

Test Plan (ENTRIES_NUM=8, IDX_W=3, QOS_HI_TH=8, STARVE_TH=2):
1. Reset, then upd with vec=0x00 -> sel_vld=0, req_entry_ptr_sel=0x00, sel_idx=0 on every cycle.
2. Low-class round-robin:
   - upd vec=0x25, all qos=2 -> next cycle sel_idx=0.
   - Ack -> 2; ack -> 5; ack -> sel_vld=0.
   - Re-upd vec=0x25 -> first pick is 0 (ptr_lo wrapped from 6 to 0 via search).
3. Class priority: upd vec=0x81, qos7=12, qos0=1 -> sel_idx=7, sel_hi=1. Ack -> sel_idx=0, sel_hi=0.
4. Starvation, HNI_QOS_STARVE_EN defined:
   - upd vec=0x0F; entries 0-2 qos=9, entry 3 qos=0.
   - Acks give 0, 1, then 3 (forced low); then 2.
   - Undefined: order is 0, 1, 2, 3.
5. Simultaneous events:
   - With pick idx=2 (low), assert sel_ack and upd vec=0x04 in the same cycle -> next cycle vec_q=0x04, ptr_lo=3, pick idx=2.
6. Mid-run reset: assert rst asynchronously between edges while sel_vld=1 -> outputs 0 within the same cycle; after release, upd vec=0x80 -> sel_idx=7.
